// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus slave: 128 KB RAM plus an I/O window (UART rx/tx, cycle counter, stop port).
// Read data is registered, so every read returns one cycle after the request.
module mem_io_responder #(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH      = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halted
);

  localparam int PTR_W     = $clog2(TX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_BYTES = 1 << RAM_ADDR_BITS;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(TX_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  logic [7:0]       r_mem [RAM_BYTES];
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [7:0]       r_rdata;
  logic [31:0]      r_cyc_cnt;
  logic [31:8]      r_snap;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_tx_ovf;
  logic             r_stop_pend;
  state_t           r_state;

  logic [31:0]              w_cyc_cnt_nxt;
  logic                     w_is_io;
  logic [2:0]               w_sub;
  logic [RAM_ADDR_BITS-1:0] w_ram_addr;
  logic                     w_ram_wr;
  logic                     w_ram_rd;
  logic                     w_io_rd;
  logic                     w_io_wr;
  logic                     w_tx_wr;
  logic                     w_stop_wr;
  logic                     w_stop_push;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic [7:0]               w_push_data;
  logic [7:0]               w_io_rdata;
  logic                     w_stop_pend_nxt;
  state_t                   w_state_nxt;
  logic                     w_unused_addr;

  // Only mem_a[17:0] takes part in decoding.
  assign w_unused_addr = ^mem_a[31:18];

  assign w_is_io    = (mem_a[17:16] == 2'b11);
  assign w_sub      = mem_a[2:0];
  assign w_ram_addr = mem_a[RAM_ADDR_BITS-1:0];
  assign w_ram_wr   = rdy_in & ~w_is_io & mem_wr;
  assign w_ram_rd   = rdy_in & ~w_is_io & ~mem_wr;
  assign w_io_rd    = rdy_in & w_is_io & ~mem_wr;
  assign w_io_wr    = rdy_in & w_is_io & mem_wr;
  assign w_tx_wr    = w_io_wr & (w_sub == 3'd0) & (mem_wdata != 8'h00) & (r_state == ST_RUN);
  assign w_stop_wr  = w_io_wr & (w_sub == 3'd4);
  assign rx_ready   = w_io_rd & (w_sub == 3'd0) & rx_valid;

  assign w_cyc_cnt_nxt = r_cyc_cnt + 32'd1;

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_sub)
      3'd0:    w_io_rdata = rx_valid ? rx_data : 8'h00;
      3'd4:    w_io_rdata = r_cyc_cnt[7:0];
      3'd5:    w_io_rdata = r_snap[15:8];
      3'd6:    w_io_rdata = r_snap[23:16];
      3'd7:    w_io_rdata = r_snap[31:24];
      default: w_io_rdata = 8'h00;
    endcase
  end

  // NOTE: RAM and FIFO storage carry no reset; only their control state is cleared.
  always_ff @(posedge clk_in) begin
    if (w_ram_wr) r_mem[w_ram_addr] <= mem_wdata;
    if (w_push)   r_fifo[r_wr_ptr]  <= w_push_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rdata   <= 8'h00;
      r_cyc_cnt <= 32'd0;
      r_snap    <= 24'd0;
    end else begin
      r_cyc_cnt <= w_cyc_cnt_nxt;
      if (w_ram_rd)     r_rdata <= r_mem[w_ram_addr];
      else if (w_io_rd) r_rdata <= w_io_rdata;
      if (w_io_rd && (w_sub == 3'd4)) r_snap <= r_cyc_cnt[31:8];
    end
  end

  // Tx FIFO: a user byte has priority over a pending stop marker in the same cycle.
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = (w_tx_wr | w_stop_push) & ~w_full;
  assign w_pop       = (r_count != '0) & tx_ready;
  assign w_push_data = w_stop_push ? 8'h00 : mem_wdata;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_tx_wr && w_full) r_tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= ST_RUN;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_stop_pend_nxt = r_stop_pend;
    w_stop_push     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_stop_wr || r_stop_pend) begin
          if (!w_full && !w_tx_wr) begin
            w_stop_push     = 1'b1;
            w_stop_pend_nxt = 1'b0;
            w_state_nxt     = ST_DRAIN;
          end else begin
            w_stop_pend_nxt = 1'b1;
          end
        end
      end
      ST_DRAIN:  if (r_count == '0) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  assign mem_rdata      = r_rdata;
  assign tx_valid       = (r_count != '0);
  assign io_buffer_full = (r_count >= ALMOST_CNT);
  assign tx_data        = r_fifo[r_rd_ptr];
  assign halted         = (r_state == ST_HALTED);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, rx/tx paths, cycle counter, stop sequencing and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  mem_io_responder #(.RAM_ADDR_BITS(17), .TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_buffer_full(io_buffer_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halted(halted)
  );

  // Drive one bus cycle and return at the following falling edge.
  task automatic bus(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] wd);
    rdy_in = rdy; mem_a = a; mem_wr = wr; mem_wdata = wd;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    rst_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rdy_in = 1'b0; mem_a = 32'h0; mem_wr = 1'b0; mem_wdata = 8'h00;
    @(negedge clk_in);
    idle(2);
    n_tests++; if (mem_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", mem_rdata); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", io_buffer_full); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    n_tests++; if (dut.r_cyc_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cyc_cnt: got %h want 0", dut.r_cyc_cnt); end
    // Counter starts at 0 on the first edge out of reset and keeps running while rdy_in is low.
    rst_in = 1'b1;
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h00) begin n_fail++; $display("FAIL cnt_first: got %h want 00", mem_rdata); end
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h01) begin n_fail++; $display("FAIL cnt_second: got %h want 01", mem_rdata); end
    idle(3);
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h05) begin n_fail++; $display("FAIL cnt_free_run: got %h want 05", mem_rdata); end
  endtask

  task automatic test_ram;
    bus(1'b1, 32'h0000_0010, 1'b1, 8'hA5);
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_0010: got %h want a5", mem_rdata); end
    bus(1'b1, 32'h0001_FFFF, 1'b1, 8'h3C);
    bus(1'b1, 32'h0001_FFFF, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h3C) begin n_fail++; $display("FAIL ram_1ffff: got %h want 3c", mem_rdata); end
    bus(1'b1, 32'h0000_0020, 1'b1, 8'h11);
    bus(1'b1, 32'h0000_0021, 1'b1, 8'h22);
    bus(1'b1, 32'h0000_0020, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h11) begin n_fail++; $display("FAIL ram_b2b_0: got %h want 11", mem_rdata); end
    bus(1'b1, 32'h0000_0021, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h22) begin n_fail++; $display("FAIL ram_b2b_1: got %h want 22", mem_rdata); end
  endtask

  task automatic test_rdy_low;
    bus(1'b1, 32'h0000_0044, 1'b1, 8'h88);
    bus(1'b1, 32'h0000_0040, 1'b1, 8'h77);
    bus(1'b1, 32'h0000_0040, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h77) begin n_fail++; $display("FAIL rdy_setup: got %h want 77", mem_rdata); end
    bus(1'b0, 32'h0000_0040, 1'b1, 8'h99);
    n_tests++; if (mem_rdata !== 8'h77) begin n_fail++; $display("FAIL rdy_hold_wr: got %h want 77", mem_rdata); end
    bus(1'b0, 32'h0000_0044, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h77) begin n_fail++; $display("FAIL rdy_hold_rd: got %h want 77", mem_rdata); end
    bus(1'b1, 32'h0000_0040, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h77) begin n_fail++; $display("FAIL rdy_no_write: got %h want 77", mem_rdata); end
  endtask

  task automatic test_rx;
    rx_valid = 1'b1; rx_data = 8'h5A;
    rdy_in = 1'b0; mem_a = 32'h0003_0000; mem_wr = 1'b0;
    #1;
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_rdy_low: got %b want 0", rx_ready); end
    rdy_in = 1'b1;
    #1;
    n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_pulse: got %b want 1", rx_ready); end
    @(negedge clk_in);
    n_tests++; if (mem_rdata !== 8'h5A) begin n_fail++; $display("FAIL rx_data: got %h want 5a", mem_rdata); end
    rdy_in = 1'b0;
    #1;
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_single: got %b want 0", rx_ready); end
    @(negedge clk_in);
    rx_valid = 1'b0;
    rdy_in = 1'b1; mem_a = 32'h0003_0000; mem_wr = 1'b0;
    #1;
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_empty_pulse: got %b want 0", rx_ready); end
    @(negedge clk_in);
    n_tests++; if (mem_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_empty_data: got %h want 00", mem_rdata); end
  endtask

  task automatic test_counter;
    force dut.r_cyc_cnt = 32'h1234_5678;
    bus(1'b1, 32'h0003_0004, 1'b0, 8'h00);
    release dut.r_cyc_cnt;
    n_tests++; if (mem_rdata !== 8'h78) begin n_fail++; $display("FAIL cnt_b0: got %h want 78", mem_rdata); end
    bus(1'b1, 32'h0003_0005, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h56) begin n_fail++; $display("FAIL cnt_b1: got %h want 56", mem_rdata); end
    bus(1'b1, 32'h0003_0006, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h34) begin n_fail++; $display("FAIL cnt_b2: got %h want 34", mem_rdata); end
    bus(1'b1, 32'h0003_0007, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h12) begin n_fail++; $display("FAIL cnt_b3: got %h want 12", mem_rdata); end
    bus(1'b1, 32'h0003_0003, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'h00) begin n_fail++; $display("FAIL io_other: got %h want 00", mem_rdata); end
    force dut.r_cyc_cnt = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (dut.w_cyc_cnt_nxt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", dut.w_cyc_cnt_nxt); end
    release dut.r_cyc_cnt;
    @(negedge clk_in);
  endtask

  task automatic test_tx;
    logic [7:0] b;
    tx_ready = 1'b0;
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h41);
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h00);
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h42);
    n_tests++; if (dut.r_count !== 4'd2) begin n_fail++; $display("FAIL tx_count2: got %0d want 2", dut.r_count); end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_head: got %b/%h want 1/41", tx_valid, tx_data); end
    for (int i = 0; i < 4; i++) begin
      b = 8'h43 + 8'(i);
      bus(1'b1, 32'h0003_0000, 1'b1, b);
    end
    n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL tx_full_at6: got %b want 0", io_buffer_full); end
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h47);
    n_tests++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_at7: got %b want 1", io_buffer_full); end
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h48);
    n_tests++; if (dut.r_tx_ovf !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_at8: got %b want 0", dut.r_tx_ovf); end
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h49);
    n_tests++; if (dut.r_tx_ovf !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_9th: got %b want 1", dut.r_tx_ovf); end
    n_tests++; if (dut.r_count !== 4'd8) begin n_fail++; $display("FAIL tx_count8: got %0d want 8", dut.r_count); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'h41 + 8'(i);
      n_tests++; if (tx_valid !== 1'b1 || tx_data !== b) begin n_fail++; $display("FAIL tx_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, b); end
      idle(1);
    end
    n_tests++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL tx_empty: got %b/%b want 0/0", tx_valid, io_buffer_full); end
    n_tests++; if (dut.r_tx_ovf !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_sticky: got %b want 1", dut.r_tx_ovf); end
    tx_ready = 1'b0;
  endtask

  task automatic test_stop;
    logic [7:0] exp [4];
    exp[0] = 8'h51; exp[1] = 8'h52; exp[2] = 8'h53; exp[3] = 8'h00;
    tx_ready = 1'b0;
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h51);
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h52);
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h53);
    bus(1'b1, 32'h0003_0004, 1'b1, 8'hFF);
    n_tests++; if (dut.r_count !== 4'd4) begin n_fail++; $display("FAIL stop_count4: got %0d want 4", dut.r_count); end
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h60);
    n_tests++; if (dut.r_count !== 4'd4) begin n_fail++; $display("FAIL stop_drain_ignore: got %0d want 4", dut.r_count); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin n_fail++; $display("FAIL stop_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]); end
      idle(1);
    end
    n_tests++; if (halted !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL stop_not_yet: got %b/%b want 0/0", halted, tx_valid); end
    idle(1);
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL stop_halted: got %b want 1", halted); end
    tx_ready = 1'b0;
    bus(1'b1, 32'h0003_0000, 1'b1, 8'h61);
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL halted_tx_ignore: got %b want 0", tx_valid); end
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'hA5) begin n_fail++; $display("FAIL halted_ram: got %h want a5", mem_rdata); end
  endtask

  task automatic test_full_stop_reset;
    logic [7:0] b;
    rst_in = 1'b0;
    idle(1);
    rst_in = 1'b1;
    n_tests++; if (halted !== 1'b0 || dut.r_tx_ovf !== 1'b0) begin n_fail++; $display("FAIL rst2_state: got %b/%b want 0/0", halted, dut.r_tx_ovf); end
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'h81 + 8'(i);
      bus(1'b1, 32'h0003_0000, 1'b1, b);
    end
    bus(1'b1, 32'h0003_0004, 1'b1, 8'h01);
    n_tests++; if (dut.r_stop_pend !== 1'b1 || dut.r_count !== 4'd8) begin n_fail++; $display("FAIL stop_full_pend: got %b/%0d want 1/8", dut.r_stop_pend, dut.r_count); end
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    n_tests++; if (dut.r_count !== 4'd7 || tx_data !== 8'h82) begin n_fail++; $display("FAIL stop_full_pop: got %0d/%h want 7/82", dut.r_count, tx_data); end
    idle(1);
    n_tests++; if (dut.r_count !== 4'd8 || dut.r_stop_pend !== 1'b0) begin n_fail++; $display("FAIL stop_retry: got %0d/%b want 8/0", dut.r_count, dut.r_stop_pend); end
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'hA5 || halted !== 1'b0) begin n_fail++; $display("FAIL drain_ram: got %h/%b want a5/0", mem_rdata, halted); end
    rst_in = 1'b0;
    idle(1);
    n_tests++; if (halted !== 1'b0 || tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL drain_rst_out: got %b/%b/%b want 0/0/0", halted, tx_valid, io_buffer_full); end
    n_tests++; if (mem_rdata !== 8'h00) begin n_fail++; $display("FAIL drain_rst_rdata: got %h want 00", mem_rdata); end
    rst_in = 1'b1;
    tx_ready = 1'b1;
    idle(3);
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_rst_stays_run: got %b want 0", halted); end
    bus(1'b1, 32'h0000_0010, 1'b0, 8'h00);
    n_tests++; if (mem_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_survives_rst: got %h want a5", mem_rdata); end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ram;
    test_rdy_low;
    test_rx;
    test_counter;
    test_tx;
    test_stop;
    test_full_stop_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Slave end of the CPU's byte-wide memory bus. Each cycle it accepts one read or write from the core on the address/data/write-enable lines and returns read data on the following cycle. It serves a 128 KB byte RAM and the memory-mapped I/O window at mem_a[17:16]==2'b11: UART receive/transmit, a free-running cycle counter, and the program-stop port. It also drives io_buffer_full back to the core.

## Interface
Parameters:
- RAM_ADDR_BITS, 17, byte-address width of the RAM; 2^17 bytes.
- TX_DEPTH, 8, transmit FIFO entries; must be a power of two and at least 2.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-low.
- rdy_in  in  1  bus requests are accepted only when high.
- mem_a  in  32  byte address from the core; bits [17:0] are decoded.
- mem_wr  in  1  1 = write, 0 = read.
- mem_wdata  in  8  write data from the core (the core's mem_dout).
- mem_rdata  out  8  read data to the core (the core's mem_din).
- io_buffer_full  out  1  transmit FIFO cannot accept a further byte.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  rx_data holds a byte.
- rx_ready  out  1  one-cycle pop strobe that consumes rx_data.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- halted  out  1  program stop completed and the stop byte has been drained.

## Operation
- Decode, applied only when rdy_in=1:
  - RAM when mem_a[17:16]!=2'b11, indexed by mem_a[RAM_ADDR_BITS-1:0].
  - IO when mem_a[17:16]==2'b11. Sub-address is mem_a[2:0]; all other bits are ignored.
- RAM write: mem[addr] <= mem_wdata at the clock edge.
- RAM read: mem_rdata <= mem[addr] at the clock edge.
- Read of a byte written in the previous cycle returns the new value.
- IO read, sub-address 0: if rx_valid=1, mem_rdata <= rx_data and rx_ready pulses in the same cycle as the request. Otherwise mem_rdata <= 8'h00 and there is no pulse.
- IO read, sub-address 4: mem_rdata <= cyc_cnt[7:0], and snap <= cyc_cnt.
- IO read, sub-addresses 5, 6, 7: mem_rdata <= snap[15:8], snap[23:16], snap[31:24] respectively.
- IO read, any other sub-address: 8'h00.
- IO write, sub-address 0:
  - Byte 8'h00 is ignored.
  - Otherwise the byte is pushed to the tx FIFO if not full.
  - A push into a full FIFO is dropped and sets the sticky internal flag tx_ovf, which is cleared only by reset.
- IO write, sub-address 4: requests stop (see FSM). All other IO writes are ignored.
- cyc_cnt: 32-bit counter, +1 every clock regardless of rdy_in, wraps 0xFFFFFFFF -> 0.
- Tx FIFO:
  - tx_valid = (count!=0); tx_data = head entry.
  - Pop on tx_valid & tx_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - io_buffer_full = (count >= TX_DEPTH-1). The one-entry margin covers the core's one-cycle decision lag.
- Stop FSM:
  - RUN:
    - Write to sub-address 4 pushes 8'h00 into the FIFO and moves to DRAIN.
    - If the FIFO is full, stay in RUN until a slot frees. stop_pend stays set and retries every cycle.
  - DRAIN: further tx writes are ignored. Go to HALTED when count==0.
  - HALTED: halted=1. The block stays here until reset; RAM and reads still function.
- rdy_in=0: no RAM or IO access, no rx_ready pulse, and mem_rdata holds its value. The FIFO drains, the counter runs and the FSM advances.

## Timing
- Read latency is exactly 1 cycle: a request at edge N gives valid mem_rdata after edge N+1.
- Back-to-back reads are supported, one per cycle.
- A write completes in 1 cycle and there is no wait signal.
- rx_ready is combinational on (rdy_in & IO read & sub-address 0 & rx_valid).
- io_buffer_full and tx_valid are registered from count and do not depend combinationally on the bus.
- Reset (rst_in=0 at an edge):
  - Cleared to 0: mem_rdata, cyc_cnt, snap, FIFO pointers and count, tx_ovf, stop_pend.
  - Outputs: tx_valid=0, io_buffer_full=0, halted=0, rx_ready=0, FSM=RUN.
  - RAM contents are not cleared.
- Reset mid-operation discards FIFO contents and a pending stop.
- FIFO pointers wrap modulo TX_DEPTH.

## Test plan
- RAM: write 0xA5 at 0x00010, then read 0x00010 on the next cycle; mem_rdata=0xA5 one cycle after the read. A read of 0x1FFFF after writing 0x3C returns 0x3C.
- Tx path, tx_ready held low: write 0x41, 0x00, 0x42 to 0x30000.
  - Count is 2; only 0x41 and 0x42 are pushed.
  - io_buffer_full rises when count reaches 7 (TX_DEPTH=8).
  - A 9th push sets tx_ovf.
  - Raising tx_ready drains 0x41 first.
- Rx: rx_valid=1, rx_data=0x5A, read 0x30000 → rx_ready pulses once and mem_rdata=0x5A next cycle. Same read with rx_valid=0 → 0x00 and no pulse.
- Counter: read 0x30004 at cyc_cnt=0x12345678, then 0x30005–0x30007 over the next cycles → 0x78, 0x56, 0x34, 0x12. Force cyc_cnt=0xFFFFFFFF → 0 on the next edge.
- Stop: queue 3 bytes with tx_ready=0, then write 0x30004. FIFO holds 4 entries, the last being 0x00. Enable tx_ready: halted rises the cycle after count reaches 0; a later write to 0x30000 is ignored.
- rdy_in=0 while mem_wr=1 to a RAM address → that address is unchanged and mem_rdata is held. Reset asserted during DRAIN → halted=0, tx_valid=0 after the edge.
